// File: rtl/serial_adc_pkg.sv
// Shared types and sizing helpers for the multi-channel serial ADC receiver.
package serial_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_e;

    // Width needed to hold a bit count of 0..frame_bits.
    function automatic int unsigned bit_cnt_w(input int unsigned frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

endpackage

// File: rtl/serial_adc_multi_rx_if.sv
// Sample-side bus of the serial ADC receiver: per-channel samples, strobe and status.
interface serial_adc_multi_rx_if #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_BITS = 12
);
    logic [NUM_CH*DATA_BITS-1:0] data;
    logic                        data_valid;
    logic                        busy;
    logic                        overrun;

    modport master (output data, data_valid, busy, overrun);
    modport slave  (input  data, data_valid, busy, overrun);
endinterface

// File: rtl/serial_adc_clkgen.sv
// Free-running sclk divider; ticks mark the clk cycle in which sclk is about to toggle.
module serial_adc_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk,
    output logic rise_tick_c,
    output logic fall_tick_c
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             tick_c;

    always_comb begin
        tick_c      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d   = tick_c ? '0 : div_cnt_q + DIV_W'(1);
        sclk_d      = tick_c ? ~sclk_q : sclk_q;
        rise_tick_c = tick_c & ~sclk_q;
        fall_tick_c = tick_c & sclk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk = sclk_q;
endmodule

// File: rtl/serial_adc_multi_rx.sv
// Multi-channel AD7886-class frame receiver sharing sclk/cs_n across channels.
// Build option ADC_AVG4_EN: output the truncated mean of every 4 frames per channel.
module serial_adc_multi_rx
    import serial_adc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cont,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     sdi,
    output logic                  sclk,
    output logic                  cs_n,
    serial_adc_multi_rx_if.master rx_if
);
    localparam int unsigned BC_W  = bit_cnt_w(FRAME_BITS);
    localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
    localparam int unsigned ACC_W = DATA_BITS + 2;

    state_e           state_q, state_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             start_pend_q, start_pend_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             rise_tick_c, fall_tick_c;
    logic             go_c, shift_c, load_c, out_c;
`ifdef ADC_AVG4_EN
    logic [1:0]       frm_cnt_q, frm_cnt_d;
`endif

    serial_adc_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

    // Frame sequencing: launch on a falling sclk so the first rise samples the MSB.
    always_comb begin
        state_d      = state_q;
        cs_n_d       = cs_n_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        start_pend_d = start_pend_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        shift_c      = 1'b0;
        load_c       = 1'b0;
        go_c         = enable & (cont | start_pend_q);

        if (start && state_q == IDLE) start_pend_d = 1'b1;
        if (start && busy_q)          overrun_d    = 1'b1;
        if (!enable)                  overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_tick_c && go_c) begin
                    cs_n_d       = 1'b0;
                    bit_cnt_d    = BC_W'(FRAME_BITS);
                    busy_d       = 1'b1;
                    start_pend_d = 1'b0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_tick_c) begin
                    shift_c   = 1'b1;
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                    if (bit_cnt_q == BC_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (fall_tick_c) begin
                    cs_n_d    = 1'b1;
                    load_c    = 1'b1;
                    gap_cnt_d = GAP_W'(CS_GAP);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (fall_tick_c) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(1)) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ADC_AVG4_EN
        out_c     = load_c & (frm_cnt_q == 2'd3);
        frm_cnt_d = frm_cnt_q;
        if (!enable)     frm_cnt_d = 2'd0;
        else if (load_c) frm_cnt_d = frm_cnt_q + 2'd1;
`else
        out_c     = load_c;
`endif
        valid_d = out_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            start_pend_q <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
`ifdef ADC_AVG4_EN
            frm_cnt_q    <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            start_pend_q <= start_pend_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef ADC_AVG4_EN
            frm_cnt_q    <= frm_cnt_d;
`endif
        end
    end

    // Per-channel datapath; only the kept LSBs are stored since the leading bits are discarded.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_BITS-1:0] sr_q, sr_d;
        logic [DATA_BITS-1:0] dat_q, dat_d;
`ifdef ADC_AVG4_EN
        logic [ACC_W-1:0]     acc_q, acc_d, acc_sum_c;
`endif

        always_comb begin
            sr_d = shift_c ? {sr_q[DATA_BITS-2:0], sdi[i]} : sr_q;
`ifdef ADC_AVG4_EN
            acc_sum_c = acc_q + ACC_W'(sr_q);
            acc_d     = acc_q;
            if (!enable)     acc_d = '0;
            else if (load_c) acc_d = out_c ? '0 : acc_sum_c;
            dat_d = out_c ? acc_sum_c[ACC_W-1:2] : dat_q;
`else
            dat_d = out_c ? sr_q : dat_q;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q  <= '0;
                dat_q <= '0;
`ifdef ADC_AVG4_EN
                acc_q <= '0;
`endif
            end else begin
                sr_q  <= sr_d;
                dat_q <= dat_d;
`ifdef ADC_AVG4_EN
                acc_q <= acc_d;
`endif
            end
        end

        assign rx_if.data[i*DATA_BITS +: DATA_BITS] = dat_q;
    end

    assign cs_n             = cs_n_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.busy       = busy_q;
    assign rx_if.overrun    = overrun_q;
endmodule

// File: tb/tb_serial_adc_multi_rx.sv
// Randomized bench for serial_adc_multi_rx: ADC pin model plus frame-level scoreboard.
module tb_serial_adc_multi_rx;
    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned CS_GAP     = 1;
    localparam int CS_LOW = FRAME_BITS * 2 * CLK_DIV;
    localparam int PERIOD = (FRAME_BITS + CS_GAP + 1) * 2 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              cont = 1'b0;
    logic              start = 1'b0;
    logic [NUM_CH-1:0] sdi = '0;
    logic              sclk, cs_n;

    serial_adc_multi_rx_if #(.NUM_CH(NUM_CH), .DATA_BITS(DATA_BITS)) bus ();

    serial_adc_multi_rx #(
        .NUM_CH(NUM_CH), .FRAME_BITS(FRAME_BITS), .DATA_BITS(DATA_BITS),
        .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cont(cont), .start(start),
        .sdi(sdi), .sclk(sclk), .cs_n(cs_n), .rx_if(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_falls = 0;
    int n_valid = 0;
    bit cont_chk = 1'b0;
    bit force_first = 1'b0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ADC pin model: new word at each cs_n fall, MSB first, next bit after every sclk fall.
    int m_idx = -1;
    bit m_prev_cs = 1'b1;
    bit m_prev_sclk = 1'b0;
    int m_word[NUM_CH];
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            m_idx = -1; m_prev_cs = 1'b1; m_prev_sclk = 1'b0;
        end else begin
            if (m_prev_cs && !cs_n) begin
                logic [63:0] e;
                e = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    m_word[c] = int'($urandom_range(0, (1 << FRAME_BITS) - 1));
                    if (force_first) m_word[c] = (c == 0) ? 'h0ABC : 'h0123;
                    e = e + (64'(m_word[c] % (1 << DATA_BITS)) << (c * DATA_BITS));
                end
                force_first = 1'b0;
                exp_q.push_back(e);
                m_idx = FRAME_BITS - 1;
            end else if (!cs_n && m_prev_sclk && !sclk) begin
                m_idx--;
            end
            if (!cs_n && m_idx >= 0)
                for (int c = 0; c < NUM_CH; c++) sdi[c] = ((m_word[c] >> m_idx) & 1) != 0;
            m_prev_cs = cs_n;
            m_prev_sclk = sclk;
        end
    end

    // Monitor: cs_n timing, valid pulse width and sample scoreboard.
    int  prev_fall = -1;
    int  fall_cyc = 0;
    bit  in_frame = 1'b0;
    bit  prev_valid = 1'b0;
    bit  prev_cs = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_frame = 1'b0; prev_fall = -1; prev_valid = 1'b0; prev_cs = 1'b1;
        end else begin
            if (!cont_chk) prev_fall = -1;
            if (prev_cs && !cs_n) begin
                n_falls++;
                if (cont_chk && prev_fall >= 0) chk("frame_period", 64'(cyc - prev_fall), 64'(PERIOD));
                prev_fall = cyc;
                fall_cyc = cyc;
                in_frame = 1'b1;
            end
            if (!prev_cs && cs_n && in_frame) begin
                chk("cs_low_len", 64'(cyc - fall_cyc), 64'(CS_LOW));
                in_frame = 1'b0;
            end
            if (bus.data_valid) begin
                n_valid++;
                chk("dv_width", 64'(prev_valid), 64'(0));
                chk("dv_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) chk("data", 64'(bus.data), exp_q.pop_front());
            end
            prev_cs = cs_n;
            prev_valid = bus.data_valid;
        end
    end

    task automatic wait_falls(input int f0, input int budget);
        for (int i = 0; i < budget && n_falls == f0; i++) @(posedge clk);
        #2;
    endtask

    task automatic wait_valids(input int v0, input int budget);
        for (int i = 0; i < budget && n_valid == v0; i++) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && bus.busy; i++) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int f0, v0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(sclk), 64'(0));
        chk("rst_cs_n", 64'(cs_n), 64'(1));
        chk("rst_data", 64'(bus.data), 64'(0));
        chk("rst_valid", 64'(bus.data_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_overrun", 64'(bus.overrun), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // Continuous frames, first one with fixed words.
        force_first = 1'b1;
        cont_chk = 1'b1;
        v0 = n_valid;
        @(negedge clk) begin enable = 1'b1; cont = 1'b1; end
        wait_valids(v0, 200);
        chk("decode_seen", 64'(n_valid - v0), 64'(1));
        chk("decode_first", 64'(bus.data), 64'h123ABC);
        repeat (3) begin
            v0 = n_valid;
            wait_valids(v0, 200);
        end

        // Drop enable at bit 5 of a frame: it completes, nothing new starts.
        f0 = n_falls;
        wait_falls(f0, 200);
        repeat (5) @(posedge sclk);
        v0 = n_valid;
        f0 = n_falls;
        @(negedge clk) enable = 1'b0;
        cont_chk = 1'b0;
        wait_idle(300);
        repeat (200) @(posedge clk);
        #2;
        chk("endrop_valid", 64'(n_valid - v0), 64'(1));
        chk("endrop_falls", 64'(n_falls - f0), 64'(0));
        chk("endrop_cs_n", 64'(cs_n), 64'(1));

        // Single shot.
        cont = 1'b0;
        @(negedge clk) enable = 1'b1;
        repeat ($urandom_range(1, 9)) @(negedge clk);
        f0 = n_falls; v0 = n_valid;
        pulse_start();
        wait_falls(f0, 50);
        wait_idle(300);
        repeat (250) @(posedge clk);
        #2;
        chk("single_falls", 64'(n_falls - f0), 64'(1));
        chk("single_valid", 64'(n_valid - v0), 64'(1));
        chk("single_busy", 64'(bus.busy), 64'(0));
        chk("single_cs_n", 64'(cs_n), 64'(1));
        chk("single_overrun", 64'(bus.overrun), 64'(0));

        // Overrun: second start while busy is dropped.
        f0 = n_falls; v0 = n_valid;
        pulse_start();
        wait_falls(f0, 50);
        repeat ($urandom_range(1, 12)) @(posedge sclk);
        pulse_start();
        @(posedge clk); #2;
        chk("overrun_set", 64'(bus.overrun), 64'(1));
        wait_idle(300);
        repeat (250) @(posedge clk);
        #2;
        chk("overrun_falls", 64'(n_falls - f0), 64'(1));
        chk("overrun_valid", 64'(n_valid - v0), 64'(1));
        chk("overrun_sticky", 64'(bus.overrun), 64'(1));
        @(negedge clk) enable = 1'b0;
        @(negedge clk) enable = 1'b1;
        chk("overrun_clear", 64'(bus.overrun), 64'(0));

        // Reset at bit 8 of a continuous frame.
        @(negedge clk) cont = 1'b1;
        cont_chk = 1'b1;
        f0 = n_falls;
        wait_falls(f0, 100);
        repeat (8) @(posedge sclk);
        @(negedge clk) rst_n = 1'b0;
        exp_q.delete();
        v0 = n_valid;
        #1;
        chk("mrst_sclk", 64'(sclk), 64'(0));
        chk("mrst_cs_n", 64'(cs_n), 64'(1));
        chk("mrst_data", 64'(bus.data), 64'(0));
        chk("mrst_valid", 64'(bus.data_valid), 64'(0));
        chk("mrst_busy", 64'(bus.busy), 64'(0));
        repeat ($urandom_range(2, 10)) @(negedge clk);
        chk("mrst_no_valid", 64'(n_valid - v0), 64'(0));
        rst_n = 1'b1;
        wait_valids(v0, 200);
        chk("post_rst_frame", 64'(n_valid - v0), 64'(1));
        v0 = n_valid;
        wait_valids(v0, 200);
        chk("post_rst_frame2", 64'(n_valid - v0), 64'(1));
        @(negedge clk) enable = 1'b0;
        cont_chk = 1'b0;
        wait_idle(300);
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
